// File: rtl/pc_redirect_sequencer.sv
// pc_redirect_sequencer: owns the fetch PC of the 5-stage pipeline.
// Computes branch / jump / jump-register targets from ID-stage fields, loads
// them into the PC (or defers them across hazard stalls), raises a one-cycle
// IF flush after every target load and counts applied redirects (saturating).
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   stall            hazard-unit stall; PC holds while high
//   id_valid         ID stage holds a valid instruction
//   id_branch        conditional branch in ID
//   id_cond_true     branch condition evaluated true
//   id_jump          J/JAL in ID
//   id_jr            JR in ID
//   id_imm16         branch offset field
//   id_target26      jump target field
//   id_rs_data       forwarded rs value for JR
//   id_pc_plus4      PC+4 of the ID instruction
//   pc_out           current fetch PC
//   if_flush         squash IF/ID, one-cycle pulse after a target load
//   redirect_pending a redirect is latched, waiting for stall release
//   taken_count      saturating count of applied redirects
module pc_redirect_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_cond_true,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic [15:0]      id_imm16,
    input  logic [25:0]      id_target26,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_pc_plus4,
    output logic [31:0]      pc_out,
    output logic             if_flush,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] taken_count
);

    localparam int unsigned PC_W = 32;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  tgt_q, tgt_d;
    logic             flush_q, flush_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PC_W-1:0]  br_tgt_c;
    logic [PC_W-1:0]  j_tgt_c;
    logic [PC_W-1:0]  jr_tgt_c;
    logic [PC_W-1:0]  target_c;
    logic             redir_req_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Redirect target arithmetic, all modulo 2^32
    assign br_tgt_c = id_pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00};
    assign j_tgt_c  = {id_pc_plus4[31:28], id_target26, 2'b00};
    assign jr_tgt_c = id_rs_data & 32'hFFFF_FFFC;

    // Priority jr > jump > branch
    assign target_c = id_jr   ? jr_tgt_c :
                      id_jump ? j_tgt_c  : br_tgt_c;

    // An instruction in ID while the flush pulse is high is being squashed
    assign redir_req_c = id_valid & ~flush_q &
                         (id_jr | id_jump | (id_branch & id_cond_true));

    // Saturating increment
    assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        flush_d = 1'b0;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (redir_req_c) begin
                    if (!stall) begin
                        pc_d    = target_c;
                        flush_d = 1'b1;
                        cnt_d   = cnt_inc_c;
                    end else begin
                        tgt_d   = target_c;
                        pend_d  = 1'b1;
                        state_d = ST_PEND;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + PC_W'(4);
                end
            end
            ST_PEND: begin
                // New requests ignored: the stalled ID instruction repeats
                if (!stall) begin
                    pc_d    = tgt_q;
                    flush_d = 1'b1;
                    cnt_d   = cnt_inc_c;
                    pend_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            flush_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            flush_q <= flush_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_out           = pc_q;
    assign if_flush         = flush_q;
    assign redirect_pending = pend_q;
    assign taken_count      = cnt_q;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Testbench for pc_redirect_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural model of the fetch-PC rules.
// A narrow counter keeps the saturation scenario short.
module tb_pc_redirect_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             id_valid;
    logic             id_branch;
    logic             id_cond_true;
    logic             id_jump;
    logic             id_jr;
    logic [15:0]      id_imm16;
    logic [25:0]      id_target26;
    logic [31:0]      id_rs_data;
    logic [31:0]      id_pc_plus4;
    logic [31:0]      pc_out;
    logic             if_flush;
    logic             redirect_pending;
    logic [CNT_W-1:0] taken_count;

    pc_redirect_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .id_valid         (id_valid),
        .id_branch        (id_branch),
        .id_cond_true     (id_cond_true),
        .id_jump          (id_jump),
        .id_jr            (id_jr),
        .id_imm16         (id_imm16),
        .id_target26      (id_target26),
        .id_rs_data       (id_rs_data),
        .id_pc_plus4      (id_pc_plus4),
        .pc_out           (pc_out),
        .if_flush         (if_flush),
        .redirect_pending (redirect_pending),
        .taken_count      (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_flush;
    bit          m_pending;
    logic [31:0] m_ptgt;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_target();
        logic [31:0] t;
        if (id_jr)
            t = {id_rs_data[31:2], 2'b00};
        else if (id_jump)
            t = (id_pc_plus4 & 32'hF000_0000) | ({6'd0, id_target26} << 2);
        else
            t = id_pc_plus4 + 32'($signed(id_imm16)) * 32'd4;
        return t;
    endfunction

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_flush   = 1'b0;
        m_pending = 0;
        m_ptgt    = 32'd0;
        m_cnt     = 0;
    endtask

    // Apply one clock edge's worth of the fetch-PC rules
    task automatic model_edge();
        bit req;
        logic [31:0] tgt;
        bit load;
        req  = id_valid && !m_flush && (id_jr || id_jump || (id_branch && id_cond_true));
        tgt  = model_target();
        load = 0;
        if (m_pending) begin
            if (!stall) begin
                tgt       = m_ptgt;
                load      = 1;
                m_pending = 0;
            end
        end else if (req) begin
            if (!stall) load = 1;
            else begin
                m_ptgt    = tgt;
                m_pending = 1;
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
        end
        if (load) begin
            m_pc = tgt;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        m_flush = load;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    pc_out, m_pc);
        chk({tag, ".flush"}, 32'(if_flush), 32'(m_flush));
        chk({tag, ".pend"},  32'(redirect_pending), 32'(m_pending));
        chk({tag, ".cnt"},   32'(taken_count), m_cnt);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall        = 1'b0;
        id_valid     = 1'b0;
        id_branch    = 1'b0;
        id_cond_true = 1'b0;
        id_jump      = 1'b0;
        id_jr        = 1'b0;
        id_imm16     = 16'd0;
        id_target26  = 26'd0;
        id_rs_data   = 32'd0;
        id_pc_plus4  = 32'd0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #3;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b1;
        #1;

        // Sequential fetch
        for (int i = 0; i < 3; i++) step("seq");
        chk("seq_lit", pc_out, 32'h0000_000C);

        // Taken branch backwards by one word
        id_valid = 1'b1; id_branch = 1'b1; id_cond_true = 1'b1;
        id_pc_plus4 = 32'h0000_0100; id_imm16 = 16'hFFFF;
        step("br");
        chk("br_lit", pc_out, 32'h0000_00FC);
        chk("br_flush_lit", 32'(if_flush), 32'd1);
        id_cond_true = 1'b0;
        step("br_flush");
        chk("flush_drop_lit", 32'(if_flush), 32'd0);
        step("br_nt");
        chk("br_nt_lit", pc_out, 32'h0000_0104);

        // Jump keeps the upper nibble of PC+4
        id_branch = 1'b0; id_jump = 1'b1;
        id_pc_plus4 = 32'hA000_0010; id_target26 = 26'h0000040;
        step("j");
        chk("j_lit", pc_out, 32'hA000_0100);
        id_valid = 1'b0; id_jump = 1'b0;
        step("j_flush");

        // JR wins over a simultaneous branch and clears low bits
        id_valid = 1'b1; id_jr = 1'b1; id_branch = 1'b1; id_cond_true = 1'b1;
        id_rs_data = 32'h0040_0007; id_imm16 = 16'h0010;
        step("jr");
        chk("jr_lit", pc_out, 32'h0040_0004);
        idle_inputs();
        step("jr_flush");

        // Branch arriving under a 3-cycle stall
        id_valid = 1'b1; id_branch = 1'b1; id_cond_true = 1'b1;
        id_pc_plus4 = 32'h0000_2000; id_imm16 = 16'h0008;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall_pend_lit", 32'(redirect_pending), 32'd1);
        id_imm16 = 16'h0100;  // repeated instruction must not change the latched target
        stall = 1'b0;
        step("release");
        chk("release_lit", pc_out, 32'h0000_2020);
        step("release_flush");
        idle_inputs();
        step("release_after");

        // Async reset in the middle of a pending redirect
        id_valid = 1'b1; id_jump = 1'b1; id_pc_plus4 = 32'h0000_3000;
        id_target26 = 26'h0000800; stall = 1'b1;
        step("pend2");
        step("pend2");
        do_reset();
        idle_inputs();
        for (int i = 0; i < 3; i++) step("post_rst");
        chk("post_rst_lit", pc_out, RESET_PC + 32'd12);

        // Counter saturation
        id_valid = 1'b1; id_jump = 1'b1; id_pc_plus4 = 32'h0000_0000;
        id_target26 = 26'h0000010;
        for (int i = 0; i < int'(CNT_MAX) + 5; i++) begin
            step("sat");
            step("sat_fl");
        end
        chk("sat_lit", 32'(taken_count), 32'(CNT_MAX));
        idle_inputs();
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            stall        = ($urandom_range(0, 9) < 3);
            id_valid     = ($urandom_range(0, 9) < 7);
            id_branch    = ($urandom_range(0, 3) == 0);
            id_cond_true = $urandom_range(0, 1) == 1;
            id_jump      = ($urandom_range(0, 7) == 0);
            id_jr        = ($urandom_range(0, 9) == 0);
            id_imm16     = 16'($urandom);
            id_target26  = 26'($urandom);
            id_rs_data   = $urandom;
            id_pc_plus4  = $urandom;
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_redirect_sequencer.md
Name: pc_redirect_sequencer

Overview:
- Owns the fetch PC register of the 5-stage pipeline.
- Computes redirect targets from the ID stage:
  - branch: PC+4 + sign-extended imm16 shifted left 2
  - jump: 26-bit target
  - jump-register: register value
- Sequences PC update, one-cycle IF flush and redirect deferral across hazard-unit stalls.
- Sits between the hazard unit, ID-stage decode/compare logic and instruction-memory address.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of saturating taken-redirect counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit stall; PC must hold while 1.
- id_valid  input  1  ID stage holds a valid instruction.
- id_branch  input  1  ID instruction is a conditional branch.
- id_cond_true  input  1  branch condition evaluated true in ID.
- id_jump  input  1  ID instruction is J/JAL.
- id_jr  input  1  ID instruction is JR.
- id_imm16  input  16  branch offset field.
- id_target26  input  26  jump target field.
- id_rs_data  input  32  forwarded rs value for JR.
- id_pc_plus4  input  32  PC+4 of the ID instruction.
- pc_out  output  32  current fetch PC.
- if_flush  output  1  squash IF/ID register, one-cycle pulse.
- redirect_pending  output  1  a redirect is latched and waiting for stall release.
- taken_count  output  CNT_W  number of redirects applied, saturating.

Behaviour:
- Reset (reset=0, async): pc_out=RESET_PC, if_flush=0, redirect_pending=0, taken_count=0, pend_target=0, state=RUN. Deassertion takes effect at the next rising edge.
- Target arithmetic, all mod 2^32:
  - br_tgt = id_pc_plus4 + {{14{id_imm16[15]}}, id_imm16, 2'b00}
  - j_tgt = {id_pc_plus4[31:28], id_target26, 2'b00}
  - jr_tgt = {id_rs_data[31:2], 2'b00}
- redir_req = id_valid & ~if_flush & (id_jr | id_jump | (id_branch & id_cond_true)).
- Target priority: jr > jump > branch. Multiple asserted is illegal but deterministic.
- State RUN:
  - redir_req=1, stall=0: pc_out<=target, if_flush<=1, taken_count++; stay RUN.
  - redir_req=1, stall=1: pend_target<=target, redirect_pending<=1, pc_out holds, go PEND.
  - redir_req=0, stall=0: pc_out<=pc_out+4 (wraps 0xFFFFFFFC->0).
  - redir_req=0, stall=1: pc_out holds.
- State PEND:
  - redir_req is ignored: the same stalled ID instruction repeats and must not double-count.
  - stall=1: hold everything.
  - stall=0: pc_out<=pend_target, if_flush<=1, taken_count++, redirect_pending<=0, go RUN.
- if_flush: registered; 1 for exactly the cycle after a target load, otherwise 0.
- Redirects presented while if_flush=1 are ignored: the ID instruction is being squashed.
- Latency: 1 clock from redirect decision (or stall release in PEND) to pc_out showing the target.
- taken_count: saturates at all-ones, no wrap.
- Reset mid-PEND: pending target discarded; pc_out=RESET_PC immediately (asynchronous).

Test Plan:
- Reset low then released, stall=0, no redirects -> pc_out 0x0,0x4,0x8,0xC on successive edges; if_flush=0; taken_count=0.
- pc_plus4=0x100, branch, cond_true, imm16=0xFFFF -> next pc_out=0x000000FC, if_flush=1 for one cycle, taken_count=1; with cond_true=0 -> pc_out continues +4.
- id_jump, pc_plus4=0xA0000010, target26=0x0000040 -> pc_out=0xA0000100.
- id_jr, rs_data=0x00400007 with id_branch also asserted -> pc_out=0x00400004 (JR wins, low bits cleared).
- Branch taken while stall=1 held 3 cycles -> pc_out frozen, redirect_pending=1 for 3 cycles, taken_count unchanged; one cycle after stall drops pc_out=target, if_flush pulses once, taken_count +1 only.
- Async reset asserted mid-PEND -> pc_out=RESET_PC, redirect_pending=0 without a clock edge; after release, normal +4 fetch with no stale redirect.
- Counter forced near max via 65535 redirects -> taken_count stays 0xFFFF on further redirects.
